register_file: RTL and testbench

//   General-purpose register file for the 8-bit microprocessor datapath.
//   32 x 8-bit registers, two combinational read ports (rs, rt), one synchronous write port (rd).

---
 rtl/cpu_pkg.sv | 11 +
 rtl/register_file_if.sv | 22 ++
 rtl/rf_read_port.sv | 17 +
 rtl/register_file.sv | 35 +++
 tb/tb_register_file.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register count and types for the CPU register file
package cpu_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - decode/writeback side bundle of the register file
interface register_file_if;
  import cpu_pkg::*;

  logic      write_enable;
  reg_addr_t rs;
  reg_addr_t rt;
  reg_addr_t rd;
  data_t     write_data;
  data_t     read_data1;
  data_t     read_data2;

  modport master (
    output write_enable, rs, rt, rd, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  write_enable, rs, rt, rd, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - combinational read mux with register 0 forced to zero
module rf_read_port
  import cpu_pkg::*;
(
  input  reg_addr_t addr,
  input  data_t     regs [NUM_REGS],
  output data_t     data
);

  always_comb begin
    data = '0;
    if (addr != ZERO_REG) begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 8 register file, two combinational reads, one synchronous write
module register_file
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  register_file_if.slave bus
);

  data_t regs [NUM_REGS];

  // No write bypass: a same-address read sees the new value only after the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.write_enable && (bus.rd != ZERO_REG)) begin
      regs[bus.rd] <= bus.write_data;
    end
  end

  rf_read_port u_read_rs (
    .addr (bus.rs),
    .regs (regs),
    .data (bus.read_data1)
  );

  rf_read_port u_read_rt (
    .addr (bus.rt),
    .regs (regs),
    .data (bus.read_data2)
  );

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
`timescale 1ns/1ps
module tb_register_file;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  register_file_if rf_if ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input data_t observed, input data_t expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rf_if.write_enable = 1'b0;
    rf_if.rs = '0;
    rf_if.rt = '0;
    rf_if.rd = '0;
    rf_if.write_data = '0;

    // 1. reset and sweep
    #12;
    rf_if.rs = 5'd17;
    rf_if.rt = 5'd30;
    #1;
    check("in_reset_rd1", rf_if.read_data1, 8'h00);
    check("in_reset_rd2", rf_if.read_data2, 8'h00);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_if.rs = reg_addr_t'(i);
      rf_if.rt = reg_addr_t'(i);
      #1;
      check($sformatf("sweep_rd1_r%0d", i), rf_if.read_data1, 8'h00);
      check($sformatf("sweep_rd2_r%0d", i), rf_if.read_data2, 8'h00);
    end

    // 2. basic write/read
    rf_if.write_enable = 1'b1;
    rf_if.rd = 5'd5;
    rf_if.write_data = 8'hEF;
    tick();
    rf_if.write_enable = 1'b0;
    rf_if.rs = 5'd5;
    rf_if.rt = 5'd5;
    #1;
    check("basic_rd1", rf_if.read_data1, 8'hEF);
    check("basic_rd2", rf_if.read_data2, 8'hEF);
    rf_if.rs = 5'd4;
    rf_if.rt = 5'd6;
    #1;
    check("basic_neighbour_r4", rf_if.read_data1, 8'h00);
    check("basic_neighbour_r6", rf_if.read_data2, 8'h00);

    // 3. register 0 ignores writes
    rf_if.write_enable = 1'b1;
    rf_if.rd = 5'd0;
    rf_if.write_data = 8'hFF;
    tick();
    rf_if.write_enable = 1'b0;
    rf_if.rs = 5'd0;
    rf_if.rt = 5'd0;
    #1;
    check("zero_rd1", rf_if.read_data1, 8'h00);
    check("zero_rd2", rf_if.read_data2, 8'h00);

    // 4. write disabled, then enabled
    rf_if.write_enable = 1'b0;
    rf_if.rd = 5'd7;
    rf_if.write_data = 8'h55;
    tick();
    rf_if.rs = 5'd7;
    #1;
    check("we0_r7", rf_if.read_data1, 8'h00);
    rf_if.write_enable = 1'b1;
    tick();
    rf_if.write_enable = 1'b0;
    check("we1_r7", rf_if.read_data1, 8'h55);

    // 5. dual port and no bypass
    rf_if.write_enable = 1'b1;
    rf_if.rd = 5'd3;
    rf_if.write_data = 8'hA1;
    tick();
    rf_if.rd = 5'd9;
    rf_if.write_data = 8'h3C;
    tick();
    rf_if.write_enable = 1'b0;
    rf_if.rs = 5'd3;
    rf_if.rt = 5'd9;
    #1;
    check("dual_r3", rf_if.read_data1, 8'hA1);
    check("dual_r9", rf_if.read_data2, 8'h3C);
    rf_if.write_enable = 1'b1;
    rf_if.rd = 5'd3;
    rf_if.write_data = 8'h77;
    #1;
    check("nobypass_before", rf_if.read_data1, 8'hA1);
    tick();
    rf_if.write_enable = 1'b0;
    check("nobypass_after", rf_if.read_data1, 8'h77);
    check("nobypass_other_port", rf_if.read_data2, 8'h3C);
    check("prior_r5_kept", dut.regs[5], 8'hEF);

    // 6. async reset between edges
    rf_if.write_enable = 1'b1;
    rf_if.rd = 5'd31;
    rf_if.write_data = 8'hEF;
    tick();
    rf_if.write_enable = 1'b0;
    rf_if.rs = 5'd31;
    #1;
    check("r31_written", rf_if.read_data1, 8'hEF);
    rst_n = 1'b0;
    #1;
    check("async_rst_r31", rf_if.read_data1, 8'h00);
    check("async_rst_r9", rf_if.read_data2, 8'h00);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_r31", rf_if.read_data1, 8'h00);
    rf_if.rs = 5'd3;
    #1;
    check("post_rst_r3", rf_if.read_data1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
